numeric_entry_fsm: RTL and testbench
====================================

// Module: numeric_entry_fsm
// PURPOSE
//  PS/2 keyboard numeric-entry controller. Collects up to NUM_DIGITS decimal digits into a live BCD buffer.
//  ENTER converts the buffer to binary over NUM_DIGITS cycles, clamps it to [MIN_VAL,MAX_VAL] and commits it to `value`.
//  Sits between the PS/2 scan-code receiver and any numeric setting (BPM, step count, swing %); one instance per field.
//  Decodes make/break (F0) and extended (E0) prefixes, so key releases never re-enter digits; numeric keypad keys are accepted.
// PARAMETERS
//  NUM_DIGITS  3    max digits in the entry buffer (1..6)
//  VAL_W       10   width of committed value; must hold MAX_VAL
//  MIN_VAL     1    lower clamp bound for committed value
//  MAX_VAL     999  upper clamp bound for committed value
//  RESET_VAL   120  value loaded at reset; must lie within [MIN_VAL,MAX_VAL]
// PORTS
//  Clock      in   1             system clock; all logic on posedge
//  nReset     in   1             synchronous active-low reset
//  Enable     in   1             field selected; low = clear buffer, abort conversion, return to IDLE
//  data       in   8             PS/2 scan-code byte
//  data_en    in   1             data valid, one-cycle strobe per byte
//  value      out  VAL_W         committed, clamped value
//  set        out  1             1 = value is current; 0 = edit in progress
//  valid      out  1             one-cycle pulse on the edge that writes value
//  clamped    out  1             last commit was clamped; held until the next commit
//  busy       out  1             high while in CONVERT
//  entry_bcd  out  4*NUM_DIGITS  live buffer, ones digit in [3:0], unused digits 0
//  entry_cnt  out  $clog2(NUM_DIGITS+1)  digits currently held
// BEHAVIOUR
//  Reset (nReset=0 at edge): value=RESET_VAL, set=1, valid=0, clamped=0, busy=0, buffer=0, cnt=0, state=IDLE, prefixes clear.
//  Prefix tracker runs on every data_en while Enable=1, in every state:
//   - F0 sets brk; E0 sets ext.
//   - Any other byte is a key event; brk and ext are cleared after that byte.
//   - A key event with brk=1 is a release and is ignored.
//  Key decode (make events only):
//   - digits: main row 45,16,1E,26,25,2E,36,3D,3E,46 = 0..9; keypad 70,69,72,7A,6B,73,74,6C,75,7D = 0..9, only with ext=0.
//   - ENTER: 5A with ext 0 or 1. BACKSPACE: 66. ESC: 76.
//  States IDLE, ENTRY, CONVERT:
//   - IDLE + digit: buffer={0..,d}, cnt=1, set<=0, go to ENTRY. Other keys ignored.
//   - ENTRY + digit, cnt<NUM_DIGITS: buffer shifts left one digit, new digit into ones, cnt+1. At cnt==NUM_DIGITS: ignored.
//   - ENTRY + BACKSPACE: buffer shifts right one digit, cnt-1. If cnt becomes 0: go to IDLE with set<=1 and value unchanged.
//   - ENTRY + ESC: buffer=0, cnt=0, set<=1, value unchanged, go to IDLE.
//   - ENTRY + ENTER: go to CONVERT; acc=0, idx=NUM_DIGITS-1. busy=1 from the next cycle.
//   - CONVERT: each cycle acc<=acc*10+digit[idx], idx-1. All key events ignored; the prefix tracker still runs.
//   - Last CONVERT edge (the NUM_DIGITS-th edge after ENTER was sampled):
//       value <= clamp(acc*10+digit[0]); clamped <= (result was out of range);
//       valid=1 for one cycle; set<=1; buffer=0; cnt=0; go to IDLE.
//  Latency: ENTER sampled at edge k -> value/valid update at edge k+NUM_DIGITS.
//  Accumulator width is 4*NUM_DIGITS bits; no overflow is possible. Clamp compares the full accumulator before truncation to VAL_W.
//  Enable=0 (any state): buffer=0, cnt=0, prefixes clear, go to IDLE. set<=1. value and clamped hold. valid=0.
//   An aborted CONVERT leaves value unchanged.
//  Simultaneous: data_en is ignored on the edge Enable falls. Reset mid-CONVERT aborts and loads RESET_VAL.
//  entry_bcd and entry_cnt are registered and reflect the buffer after each edge.
// TESTING
//  1. Reset, Enable=1, make 16,3E,1E then 5A -> entry_bcd=0x182 then 0x128... exact: after 1,8,2 entry_bcd=0x182;
//     ENTER -> busy for 3 cycles, value=182, valid 1 pulse, set=1, clamped=0.
//  2. Keys 45, ENTER -> value=1 (MIN_VAL), clamped=1; later keys 2,5,0, ENTER -> value=250, clamped=0.
//  3. Bytes 16,F0,16,1E,F0,1E -> entry_cnt=2, entry_bcd=0x012 (releases add no digits).
//  4. Keypad E0-less 69,72 then E0,5A -> value=12. Then 1,2,3,4 -> entry_bcd=0x123 (4th ignored); 66 -> 0x012; 76 -> IDLE, value stays 12, set=1.
//  5. Keys 9,9,9 ENTER with MAX_VAL=300 -> value=300, clamped=1.
//     Digits then Enable=0 for one cycle -> cnt=0, value unchanged.
//  6. nReset=0 during CONVERT -> value=120, busy=0, valid never pulses; Enable=0 during CONVERT -> value unchanged, no valid pulse.

Source files
------------

// File: rtl/numeric_entry_fsm.sv
// PS/2 numeric-entry controller: collects BCD digits, converts on ENTER, clamps and commits to value.
// Latency ENTER -> value/valid is NUM_DIGITS cycles; no backpressure, bytes arriving during CONVERT are dropped.
module numeric_entry_fsm #(
    parameter int NUM_DIGITS = 3,
    parameter int VAL_W      = 10,
    parameter int MIN_VAL    = 1,
    parameter int MAX_VAL    = 999,
    parameter int RESET_VAL  = 120
) (
    input  logic                              Clock,
    input  logic                              nReset,
    input  logic                              Enable,
    input  logic [7:0]                        data,
    input  logic                              data_en,
    output logic [VAL_W-1:0]                  value,
    output logic                              set,
    output logic                              valid,
    output logic                              clamped,
    output logic                              busy,
    output logic [4*NUM_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_cnt
);
    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int AW    = BW + 4;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT} state_t;

    state_t           state, next_state;
    logic [BW-1:0]    entry_buf;
    logic [CNT_W-1:0] cnt;
    logic [BW-1:0]    acc;
    logic [IDX_W-1:0] idx;
    logic             brk, ext;

    logic             dig_hit;
    logic [3:0]       dig_val;
    logic             make_evt, is_digit, is_enter, is_bs, is_esc;
    logic [3:0]       cur_digit;
    logic [AW-1:0]    acc_next;

    // Keypad codes collide with E0-prefixed navigation keys, so they count only without ext.
    always_comb begin
        dig_hit = 1'b1;
        dig_val = 4'd0;
        case (data)
            8'h45: dig_val = 4'd0;
            8'h16: dig_val = 4'd1;
            8'h1E: dig_val = 4'd2;
            8'h26: dig_val = 4'd3;
            8'h25: dig_val = 4'd4;
            8'h2E: dig_val = 4'd5;
            8'h36: dig_val = 4'd6;
            8'h3D: dig_val = 4'd7;
            8'h3E: dig_val = 4'd8;
            8'h46: dig_val = 4'd9;
            8'h70: begin dig_val = 4'd0; dig_hit = !ext; end
            8'h69: begin dig_val = 4'd1; dig_hit = !ext; end
            8'h72: begin dig_val = 4'd2; dig_hit = !ext; end
            8'h7A: begin dig_val = 4'd3; dig_hit = !ext; end
            8'h6B: begin dig_val = 4'd4; dig_hit = !ext; end
            8'h73: begin dig_val = 4'd5; dig_hit = !ext; end
            8'h74: begin dig_val = 4'd6; dig_hit = !ext; end
            8'h6C: begin dig_val = 4'd7; dig_hit = !ext; end
            8'h75: begin dig_val = 4'd8; dig_hit = !ext; end
            8'h7D: begin dig_val = 4'd9; dig_hit = !ext; end
            default: dig_hit = 1'b0;
        endcase
    end

    assign make_evt  = Enable && data_en && (data != 8'hF0) && (data != 8'hE0) && !brk;
    assign is_digit  = make_evt && dig_hit;
    assign is_enter  = make_evt && (data == 8'h5A);
    assign is_bs     = make_evt && (data == 8'h66);
    assign is_esc    = make_evt && (data == 8'h76);
    assign cur_digit = entry_buf[4*idx +: 4];
    assign acc_next  = AW'(acc) * AW'(10) + AW'(cur_digit);

    always_ff @(posedge Clock) begin
        if (!nReset) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!Enable) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (is_digit) next_state = S_ENTRY;
                S_ENTRY: begin
                    if (is_enter)                                next_state = S_CONVERT;
                    else if (is_esc)                             next_state = S_IDLE;
                    else if (is_bs && cnt == CNT_W'(1))          next_state = S_IDLE;
                end
                S_CONVERT: if (idx == '0) next_state = S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == S_CONVERT);
        entry_bcd = entry_buf;
        entry_cnt = cnt;
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            value     <= VAL_W'(RESET_VAL);
            set       <= 1'b1;
            valid     <= 1'b0;
            clamped   <= 1'b0;
            entry_buf <= '0;
            cnt       <= '0;
            acc       <= '0;
            idx       <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!Enable) begin
                brk       <= 1'b0;
                ext       <= 1'b0;
                entry_buf <= '0;
                cnt       <= '0;
                set       <= 1'b1;
            end else begin
                if (data_en) begin
                    if (data == 8'hF0)      brk <= 1'b1;
                    else if (data == 8'hE0) ext <= 1'b1;
                    else begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end
                end
                case (state)
                    S_IDLE: begin
                        if (is_digit) begin
                            entry_buf <= BW'(dig_val);
                            cnt       <= CNT_W'(1);
                            set       <= 1'b0;
                        end
                    end
                    S_ENTRY: begin
                        if (is_digit) begin
                            if (cnt < CNT_W'(NUM_DIGITS)) begin
                                entry_buf <= (entry_buf << 4) | BW'(dig_val);
                                cnt       <= cnt + 1'b1;
                            end
                        end else if (is_bs) begin
                            entry_buf <= entry_buf >> 4;
                            cnt       <= cnt - 1'b1;
                            if (cnt == CNT_W'(1)) set <= 1'b1;
                        end else if (is_esc) begin
                            entry_buf <= '0;
                            cnt       <= '0;
                            set       <= 1'b1;
                        end else if (is_enter) begin
                            acc <= '0;
                            idx <= IDX_W'(NUM_DIGITS - 1);
                        end
                    end
                    S_CONVERT: begin
                        acc <= BW'(acc_next);
                        idx <= idx - 1'b1;
                        if (idx == '0) begin
                            // Clamp on the full-width result so out-of-range entries never wrap.
                            if (acc_next < AW'(MIN_VAL)) begin
                                value   <= VAL_W'(MIN_VAL);
                                clamped <= 1'b1;
                            end else if (acc_next > AW'(MAX_VAL)) begin
                                value   <= VAL_W'(MAX_VAL);
                                clamped <= 1'b1;
                            end else begin
                                value   <= VAL_W'(acc_next);
                                clamped <= 1'b0;
                            end
                            valid     <= 1'b1;
                            set       <= 1'b1;
                            entry_buf <= '0;
                            cnt       <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_numeric_entry_fsm.sv
// Directed bench for numeric_entry_fsm (3 digits, clamp range 1..300, reset value 120).
module tb_numeric_entry_fsm;
    logic        Clock = 1'b0;
    logic        nReset;
    logic        Enable;
    logic [7:0]  data;
    logic        data_en;
    logic [9:0]  value;
    logic        set, valid, clamped, busy;
    logic [11:0] entry_bcd;
    logic [1:0]  entry_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cycles, valid_pulses;

    always #5 Clock = ~Clock;

    numeric_entry_fsm #(
        .NUM_DIGITS(3), .VAL_W(10), .MIN_VAL(1), .MAX_VAL(300), .RESET_VAL(120)
    ) dut (
        .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data), .data_en(data_en),
        .value(value), .set(set), .valid(valid), .clamped(clamped), .busy(busy),
        .entry_bcd(entry_bcd), .entry_cnt(entry_cnt)
    );

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        data    = b;
        data_en = 1'b1;
        @(negedge Clock);
        data_en = 1'b0;
    endtask

    task automatic watch(input int n);
        busy_cycles  = 0;
        valid_pulses = 0;
        repeat (n) begin
            if (busy === 1'b1)  busy_cycles++;
            if (valid === 1'b1) valid_pulses++;
            @(negedge Clock);
        end
    endtask

    task automatic test_reset;
        nReset = 1'b0; Enable = 1'b1; data = 8'h00; data_en = 1'b0;
        repeat (2) @(negedge Clock);
        n_cmp++; if (value !== 10'd120) begin n_err++; $display("FAIL reset_value got %0d want 120", value); end
        n_cmp++; if ({set, valid, clamped, busy} !== 4'b1000) begin n_err++; $display("FAIL reset_flags got %b want 1000", {set, valid, clamped, busy}); end
        n_cmp++; if ({entry_bcd, entry_cnt} !== 14'd0) begin n_err++; $display("FAIL reset_buf got %h/%0d want 0/0", entry_bcd, entry_cnt); end
        nReset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_basic_entry;
        send(8'h16); send(8'h3E); send(8'h1E);
        n_cmp++; if (entry_bcd !== 12'h182 || entry_cnt !== 2'd3) begin n_err++; $display("FAIL t1_buf got %h/%0d want 182/3", entry_bcd, entry_cnt); end
        n_cmp++; if (set !== 1'b0) begin n_err++; $display("FAIL t1_set_editing got %b want 0", set); end
        send(8'h5A);
        watch(6);
        n_cmp++; if (busy_cycles != 3) begin n_err++; $display("FAIL t1_busy_cycles got %0d want 3", busy_cycles); end
        n_cmp++; if (valid_pulses != 1) begin n_err++; $display("FAIL t1_valid_pulses got %0d want 1", valid_pulses); end
        n_cmp++; if (value !== 10'd182 || clamped !== 1'b0 || set !== 1'b1) begin n_err++; $display("FAIL t1_commit got %0d c%b s%b want 182 c0 s1", value, clamped, set); end
        n_cmp++; if (entry_cnt !== 2'd0 || entry_bcd !== 12'h000) begin n_err++; $display("FAIL t1_buf_clear got %h/%0d want 0/0", entry_bcd, entry_cnt); end
    endtask

    task automatic test_clamp_low;
        send(8'h45);
        n_cmp++; if (entry_cnt !== 2'd1 || set !== 1'b0) begin n_err++; $display("FAIL t2_zero_digit got cnt %0d set %b want 1/0", entry_cnt, set); end
        send(8'h5A);
        watch(6);
        n_cmp++; if (value !== 10'd1 || clamped !== 1'b1) begin n_err++; $display("FAIL t2_min_clamp got %0d c%b want 1 c1", value, clamped); end
        send(8'h1E); send(8'h2E); send(8'h45); send(8'h5A);
        watch(6);
        n_cmp++; if (value !== 10'd250 || clamped !== 1'b0 || valid_pulses != 1) begin n_err++; $display("FAIL t2_250 got %0d c%b v%0d want 250 c0 v1", value, clamped, valid_pulses); end
    endtask

    task automatic test_release;
        send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
        n_cmp++; if (entry_bcd !== 12'h012 || entry_cnt !== 2'd2) begin n_err++; $display("FAIL t3_release got %h/%0d want 012/2", entry_bcd, entry_cnt); end
        send(8'h66);
        n_cmp++; if (entry_bcd !== 12'h001 || entry_cnt !== 2'd1) begin n_err++; $display("FAIL t3_bs got %h/%0d want 001/1", entry_bcd, entry_cnt); end
        send(8'h66);
        n_cmp++; if (entry_cnt !== 2'd0 || set !== 1'b1 || value !== 10'd250) begin n_err++; $display("FAIL t3_bs_empty got cnt %0d set %b val %0d want 0/1/250", entry_cnt, set, value); end
    endtask

    task automatic test_keypad_edit;
        send(8'hE0); send(8'h69);
        n_cmp++; if (entry_cnt !== 2'd0) begin n_err++; $display("FAIL t4_ext_keypad got cnt %0d want 0", entry_cnt); end
        send(8'h69); send(8'h72); send(8'hE0); send(8'h5A);
        watch(6);
        n_cmp++; if (value !== 10'd12 || valid_pulses != 1) begin n_err++; $display("FAIL t4_keypad got %0d v%0d want 12 v1", value, valid_pulses); end
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        n_cmp++; if (entry_bcd !== 12'h123 || entry_cnt !== 2'd3) begin n_err++; $display("FAIL t4_full got %h/%0d want 123/3", entry_bcd, entry_cnt); end
        send(8'h66);
        n_cmp++; if (entry_bcd !== 12'h012 || entry_cnt !== 2'd2) begin n_err++; $display("FAIL t4_bs got %h/%0d want 012/2", entry_bcd, entry_cnt); end
        send(8'h76);
        n_cmp++; if (entry_cnt !== 2'd0 || entry_bcd !== 12'h000 || set !== 1'b1 || value !== 10'd12) begin n_err++; $display("FAIL t4_esc got %h/%0d s%b v%0d want 0/0 s1 v12", entry_bcd, entry_cnt, set, value); end
    endtask

    task automatic test_clamp_high_disable;
        send(8'h46); send(8'h46); send(8'h46); send(8'h5A);
        watch(6);
        n_cmp++; if (value !== 10'd300 || clamped !== 1'b1) begin n_err++; $display("FAIL t5_max_clamp got %0d c%b want 300 c1", value, clamped); end
        send(8'h16); send(8'h1E);
        n_cmp++; if (entry_cnt !== 2'd2 || set !== 1'b0) begin n_err++; $display("FAIL t5_pre_disable got cnt %0d set %b want 2/0", entry_cnt, set); end
        Enable = 1'b0;
        @(negedge Clock);
        Enable = 1'b1;
        n_cmp++; if (entry_cnt !== 2'd0 || set !== 1'b1 || value !== 10'd300 || clamped !== 1'b1) begin n_err++; $display("FAIL t5_disable got cnt %0d s%b v%0d c%b want 0 s1 v300 c1", entry_cnt, set, value, clamped); end
    endtask

    task automatic test_abort;
        send(8'h16); send(8'h1E); send(8'h5A);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t6_busy_start got %b want 1", busy); end
        nReset = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        watch(5);
        n_cmp++; if (value !== 10'd120 || busy !== 1'b0 || valid_pulses != 0 || clamped !== 1'b0) begin n_err++; $display("FAIL t6_reset_abort got v%0d b%b p%0d c%b want 120 0 0 0", value, busy, valid_pulses, clamped); end
        send(8'h16); send(8'h5A);
        Enable = 1'b0;
        @(negedge Clock);
        Enable = 1'b1;
        watch(5);
        n_cmp++; if (value !== 10'd120 || valid_pulses != 0 || busy_cycles != 0 || set !== 1'b1) begin n_err++; $display("FAIL t6_enable_abort got v%0d p%0d b%0d s%b want 120 0 0 1", value, valid_pulses, busy_cycles, set); end
    endtask

    initial begin
        test_reset;
        test_basic_entry;
        test_clamp_low;
        test_release;
        test_keypad_edit;
        test_clamp_high_disable;
        test_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
